fpu_addsub_param: RTL

Parametrised multi-cycle floating-point add/subtract unit. Successor to the fixed 1/6/25 adder, with generic exponent and mantissa widths, a start/done handshake and an explicit add/sub mode. Adds round-to-nearest-even on guard/round/sticky bits and correct zero handling. Sits on the same 100 kHz datapath and keeps the same one-hot 4-bit status encoding.

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fpu_align_shift.sv | 34 +++
 rtl/fpu_addsub_param.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the parametrised FP add/sub unit.
package fpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        OPERATE,
        NORMALIZE,
        ROUND,
        OUTPUT
    } state_t;

    localparam logic [3:0] ST_UNDERFLOW = 4'b1000;
    localparam logic [3:0] ST_OVERFLOW  = 4'b0100;
    localparam logic [3:0] ST_INEXACT   = 4'b0010;
    localparam logic [3:0] ST_EXACT     = 4'b0001;

    function automatic int exp_max(input int ew);
        return (1 << ew) - 1;
    endfunction

endpackage

// File: rtl/fpu_align_shift.sv
// Right shifter for the small significand: appends G/R and folds
// every bit shifted past R into a sticky bit.
import fpu_pkg::*;

module fpu_align_shift #(
    parameter int MAN_W = 25,
    parameter int SH_W  = 6
) (
    input  logic [MAN_W:0]   sig,
    input  logic [SH_W-1:0]  amt,
    output logic [MAN_W+2:0] shifted,
    output logic             sticky
);

    localparam int FW = MAN_W + 3;

    logic [FW-1:0] full;

    assign full = {sig, 2'b00};

    always_comb begin
        shifted = '0;
        sticky  = 1'b0;
        if (32'(amt) > MAN_W + 2) begin
            sticky = |sig;
        end else begin
            shifted = full >> amt;
            for (int i = 0; i < FW; i++) begin
                if (i < 32'(amt)) sticky = sticky | full[i];
            end
        end
    end

endmodule

// File: rtl/fpu_addsub_param.sv
// Multi-cycle FP add/sub with RNE rounding and one-hot status.
// Optional sticky status accumulator: define FPU_STICKY_FLAGS_EN.
import fpu_pkg::*;

module fpu_addsub_param #(
    parameter  int EXP_W  = 6,
    parameter  int MAN_W  = 25,
    localparam int WORD_W = 1 + EXP_W + MAN_W
) (
    input  logic              clock100KHz,
    input  logic              reset,
    input  logic              start_in,
    input  logic              op_sel_in,
    input  logic [WORD_W-1:0] op_A_in,
    input  logic [WORD_W-1:0] op_B_in,
    output logic              ready_out,
    output logic              done_out,
    output logic [WORD_W-1:0] data_out,
    output logic [3:0]        status_out
`ifdef FPU_STICKY_FLAGS_EN
    ,
    input  logic              clear_flags_in,
    output logic [3:0]        flags_acc_out
`endif
);

    localparam int SIG_W  = MAN_W + 5;
    localparam int EMAX_I = exp_max(EXP_W);
    localparam logic [EXP_W:0] EMAX    = EMAX_I[EXP_W:0];
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

    state_t state, state_nxt;

    logic [WORD_W-1:0] a_q, b_q;
    logic [SIG_W-1:0]  big_q, small_q, res_q;
    logic [EXP_W:0]    exp_q;
    logic [MAN_W-1:0]  man_q;
    logic              sign_big_q, sign_small_q, res_sign_q;
    logic              ovf_q, unf_q, inx_q;

    logic [EXP_W-1:0] a_exp, b_exp, big_exp, diff;
    logic [MAN_W:0]   big_sig, small_sig;
    logic [MAN_W+2:0] sh_out;
    logic             sh_sticky, swap;

    assign a_exp     = a_q[WORD_W-2 -: EXP_W];
    assign b_exp     = b_q[WORD_W-2 -: EXP_W];
    assign swap      = b_exp > a_exp;
    assign big_exp   = swap ? b_exp : a_exp;
    assign diff      = swap ? b_exp - a_exp : a_exp - b_exp;
    assign big_sig   = swap ? {|b_q[WORD_W-2:0], b_q[MAN_W-1:0]}
                            : {|a_q[WORD_W-2:0], a_q[MAN_W-1:0]};
    assign small_sig = swap ? {|a_q[WORD_W-2:0], a_q[MAN_W-1:0]}
                            : {|b_q[WORD_W-2:0], b_q[MAN_W-1:0]};

    fpu_align_shift #(
        .MAN_W (MAN_W),
        .SH_W  (EXP_W)
    ) u_align (
        .sig     (small_sig),
        .amt     (diff),
        .shifted (sh_out),
        .sticky  (sh_sticky)
    );

    logic           carry, hid, is_zero, exp_low;
    logic [EXP_W:0] exp_inc;
    logic           rnd_inc, rnd_co;
    logic [MAN_W-1:0] rnd_man;
    logic [3:0]     status_nxt;

    assign carry   = res_q[SIG_W-1];
    assign hid     = res_q[MAN_W+3];
    assign is_zero = res_q == '0;
    assign exp_low = exp_q <= EXP_ONE;
    assign exp_inc = exp_q + EXP_ONE;
    // round-to-nearest-even: G & (R | S | LSB)
    assign rnd_inc = res_q[2] & (res_q[1] | res_q[0] | res_q[3]);
    assign rnd_man = res_q[MAN_W+2:3] + {{(MAN_W-1){1'b0}}, rnd_inc};
    assign rnd_co  = rnd_inc & (&res_q[MAN_W+2:3]);

    always_comb begin
        status_nxt = ST_EXACT;
        priority case (1'b1)
            ovf_q:   status_nxt = ST_OVERFLOW;
            unf_q:   status_nxt = ST_UNDERFLOW;
            inx_q:   status_nxt = ST_INEXACT;
            default: status_nxt = ST_EXACT;
        endcase
    end

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (start_in) state_nxt = ALIGN;
            ALIGN:     state_nxt = OPERATE;
            OPERATE:   state_nxt = NORMALIZE;
            NORMALIZE: if (carry || is_zero || hid || exp_low)
                           state_nxt = ROUND;
            ROUND:     state_nxt = OUTPUT;
            OUTPUT:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    assign ready_out = state == IDLE;

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            a_q <= '0; b_q <= '0;
            big_q <= '0; small_q <= '0; res_q <= '0;
            exp_q <= '0; man_q <= '0;
            sign_big_q <= 1'b0; sign_small_q <= 1'b0;
            res_sign_q <= 1'b0;
            ovf_q <= 1'b0; unf_q <= 1'b0; inx_q <= 1'b0;
            done_out <= 1'b0; data_out <= '0; status_out <= '0;
        end else begin
            done_out <= 1'b0;
            unique case (state)
                IDLE: if (start_in) begin
                    a_q   <= op_A_in;
                    b_q   <= {op_B_in[WORD_W-1] ^ op_sel_in,
                              op_B_in[WORD_W-2:0]};
                    ovf_q <= 1'b0; unf_q <= 1'b0; inx_q <= 1'b0;
                end
                ALIGN: begin
                    big_q        <= {1'b0, big_sig, 3'b000};
                    small_q      <= {1'b0, sh_out, sh_sticky};
                    exp_q        <= {1'b0, big_exp};
                    sign_big_q   <= swap ? b_q[WORD_W-1] : a_q[WORD_W-1];
                    sign_small_q <= swap ? a_q[WORD_W-1] : b_q[WORD_W-1];
                end
                OPERATE: begin
                    if (sign_big_q == sign_small_q) begin
                        res_q      <= big_q + small_q;
                        res_sign_q <= sign_big_q;
                    end else if (big_q >= small_q) begin
                        res_q      <= big_q - small_q;
                        res_sign_q <= sign_big_q;
                    end else begin
                        res_q      <= small_q - big_q;
                        res_sign_q <= sign_small_q;
                    end
                end
                NORMALIZE: begin
                    if (carry) begin
                        res_q <= {1'b0, res_q[SIG_W-1:2], |res_q[1:0]};
                        exp_q <= exp_inc;
                        if (exp_inc >= EMAX) ovf_q <= 1'b1;
                    end else if (is_zero) begin
                        exp_q      <= '0;
                        res_sign_q <= 1'b0;
                    end else if (!hid) begin
                        if (exp_low) begin
                            unf_q <= 1'b1;
                        end else begin
                            res_q <= res_q << 1;
                            exp_q <= exp_q - EXP_ONE;
                        end
                    end else if (exp_q >= EMAX) begin
                        ovf_q <= 1'b1;
                    end
                end
                ROUND: if (!ovf_q && !unf_q) begin
                    man_q <= rnd_man;
                    inx_q <= |res_q[2:0];
                    if (rnd_co) begin
                        exp_q <= exp_inc;
                        if (exp_inc >= EMAX) ovf_q <= 1'b1;
                    end
                end
                OUTPUT: begin
                    done_out   <= 1'b1;
                    status_out <= status_nxt;
                    if (ovf_q)
                        data_out <= {res_sign_q, {EXP_W{1'b1}},
                                     {MAN_W{1'b0}}};
                    else if (unf_q)
                        data_out <= '0;
                    else
                        data_out <= {res_sign_q, exp_q[EXP_W-1:0], man_q};
                end
                default: ;
            endcase
        end
    end

`ifdef FPU_STICKY_FLAGS_EN
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset)
            flags_acc_out <= '0;
        else if (state == OUTPUT)
            flags_acc_out <= flags_acc_out | status_nxt;
        else if (clear_flags_in)
            flags_acc_out <= '0;
    end
`endif

endmodule
